// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: word width, the
// pipeline bubble encoding, the fetch FSM state and the fetch register bundle.
package mips_pkg;

  localparam int WORD_W = 32;

  // Must stay identical to the bubble the IF/ID register loads.
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0020;

  typedef enum logic {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

  // Complete architectural state of the fetch control path, kept as one
  // struct so checkers can bind to a single signal.
  typedef struct packed {
    fetch_state_t      state;
    logic              kill;
    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] req_pc;
  } fetch_regs_t;

  function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry fetched-instruction buffer. The inst register reads NOP whenever
// the entry is empty, so the IF/ID outputs come straight from flops.
module fetch_buf
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              consume,
  input  logic [WORD_W-1:0] load_pc_4,
  input  logic [WORD_W-1:0] load_inst,
  output logic              buf_vld,
  output logic [WORD_W-1:0] pc_4,
  output logic [WORD_W-1:0] inst
);

  // Clear beats load; pc_4 keeps its last value when the entry empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld <= 1'b0;
      pc_4    <= '0;
      inst    <= NOP;
    end else if (clear) begin
      buf_vld <= 1'b0;
      inst    <= NOP;
    end else if (load) begin
      buf_vld <= 1'b1;
      pc_4    <= load_pc_4;
      inst    <= load_inst;
    end else if (consume) begin
      buf_vld <= 1'b0;
      inst    <= NOP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one outstanding imem request and
// feeds IF/ID. Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP      = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] IF_pc_4,
  output logic [WORD_W-1:0] IF_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  // Handshake: a request transfers on a cycle with imem_req && imem_gnt; the
  // requester holds req/addr steady until then (flush may retarget). Exactly
  // one response follows with imem_rvalid, no earlier than the next cycle.

  fetch_regs_t r_q, r_d;
  logic        buf_vld;
  logic        consume;
  logic        gnt_fire;
  logic        resp;
  logic        load;

  assign consume   = buf_vld && !stall;
  assign gnt_fire  = imem_req && imem_gnt;
  assign resp      = (r_q.state == WAIT) && imem_rvalid;
  assign load      = resp && !r_q.kill && !flush;
  assign imem_addr = r_q.fetch_pc;

  always_comb begin
    imem_req = 1'b0;
    if (rst_n && (r_q.state == ISSUE)) begin
      imem_req = !buf_vld || consume;
    end
  end

  always_comb begin
    r_d = r_q;
    case (r_q.state)
      ISSUE: begin
        if (gnt_fire) begin
          r_d.state    = WAIT;
          r_d.req_pc   = r_q.fetch_pc;
          r_d.fetch_pc = pc_plus4(r_q.fetch_pc);
          r_d.kill     = flush;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          r_d.state = ISSUE;
          r_d.kill  = 1'b0;
        end else if (flush) begin
          r_d.kill  = 1'b1;
        end
      end
      default: r_d.state = ISSUE;
    endcase
    // A redirect overrides the post-grant increment.
    if (flush) begin
      r_d.fetch_pc = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '{state: ISSUE, kill: 1'b0, fetch_pc: RESET_PC, req_pc: '0};
    end else begin
      r_q <= r_d;
    end
  end

  fetch_buf #(
    .NOP (NOP)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (load),
    .consume   (consume),
    .load_pc_4 (pc_plus4(r_q.req_pc)),
    .load_inst (imem_rdata),
    .buf_vld   (buf_vld),
    .pc_4      (IF_pc_4),
    .inst      (IF_inst)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (resp && !r_q.kill) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!buf_vld && !stall) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus a hand-written
// reset-during-WAIT sequence and an in-order delivered-instruction queue.
module tb_fetch_unit;

  localparam logic [31:0] NOP_V = 32'h0000_0020;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] redirect;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc4;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] IF_pc_4;
  logic [31:0] IF_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  vec_t        vec[64];
  int          n_vec = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .IF_pc_4     (IF_pc_4),
    .IF_inst     (IF_inst)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic f, input logic [31:0] redir,
                     input logic g, input logic rv, input logic [31:0] rd,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic [31:0] einst, input logic [31:0] epc4);
    vec[n_vec] = '{s, f, redir, g, rv, rd, ereq, eaddr, einst, epc4};
    n_vec++;
  endtask

  task automatic drive(input logic s, input logic f, input logic [31:0] redir,
                       input logic g, input logic rv, input logic [31:0] rd);
    stall       = s;
    flush       = f;
    redirect_pc = redir;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
  endtask

  initial begin
    // stall flush redirect gnt rvalid rdata | req addr inst pc_4
    add(0, 0, 0, 1, 0, 0,            1, 32'h0,   NOP_V, 32'h0);   // c0 first fetch
    add(0, 0, 0, 0, 1, 32'h1,        0, 32'h4,   NOP_V, 32'h0);
    add(0, 0, 0, 1, 0, 0,            1, 32'h4,   32'h1, 32'h4);
    add(0, 0, 0, 0, 1, 32'h5,        0, 32'h8,   NOP_V, 32'h4);
    add(0, 0, 0, 1, 0, 0,            1, 32'h8,   32'h5, 32'h8);
    add(0, 0, 0, 0, 1, 32'h9,        0, 32'hC,   NOP_V, 32'h8);
    for (int k = 0; k < 3; k++)
      add(1, 0, 0, 0, 0, 0,          0, 32'hC,   32'h9, 32'hC);   // stall holds PC 8
    add(0, 0, 0, 1, 0, 0,            1, 32'hC,   32'h9, 32'hC);
    add(0, 0, 0, 0, 1, 32'hD,        0, 32'h10,  NOP_V, 32'hC);
    add(0, 0, 0, 1, 0, 0,            1, 32'h10,  32'hD, 32'h10);
    add(0, 1, 32'h100, 0, 0, 0,      0, 32'h14,  NOP_V, 32'h10);  // flush in WAIT
    add(0, 0, 0, 0, 1, 32'h11,       0, 32'h100, NOP_V, 32'h10);  // stale response
    add(0, 0, 0, 1, 0, 0,            1, 32'h100, NOP_V, 32'h10);
    add(0, 0, 0, 0, 1, 32'h101,      0, 32'h104, NOP_V, 32'h10);
    add(0, 0, 0, 0, 0, 0,            1, 32'h104, 32'h101, 32'h104);
    add(0, 1, 32'h200, 1, 0, 0,      1, 32'h104, NOP_V, 32'h104); // flush with gnt
    add(0, 0, 0, 0, 1, 32'h105,      0, 32'h200, NOP_V, 32'h104);
    add(0, 0, 0, 1, 0, 0,            1, 32'h200, NOP_V, 32'h104);
    add(0, 1, 32'h300, 0, 1, 32'h201, 0, 32'h204, NOP_V, 32'h104); // flush with rvalid
    add(0, 0, 0, 1, 0, 0,            1, 32'h300, NOP_V, 32'h104);
    add(0, 0, 0, 0, 1, 32'h301,      0, 32'h304, NOP_V, 32'h104);
    add(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h304, 32'h301, 32'h304);
    for (int k = 0; k < 5; k++)
      add(0, 0, 0, 0, 0, 0,          1, 32'hFFFF_FFFC, NOP_V, 32'h304); // delayed gnt
    add(0, 0, 0, 1, 0, 0,            1, 32'hFFFF_FFFC, NOP_V, 32'h304);
    add(0, 0, 0, 0, 1, 32'hFFFF_FFFD, 0, 32'h0,  NOP_V, 32'h304);  // wrapped PC
    add(0, 0, 0, 0, 0, 0,            1, 32'h0,   32'hFFFF_FFFD, 32'h0);

    exp_q = '{32'h1, 32'h5, 32'h9, 32'hD, 32'h101, 32'h301, 32'hFFFF_FFFD};

    // Reset values
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req", {31'd0, imem_req}, 32'd0);
    check("reset_inst", IF_inst, NOP_V);
    check("reset_pc4", IF_pc_4, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      drive(vec[i].stall, vec[i].flush, vec[i].redirect, vec[i].gnt, vec[i].rvalid, vec[i].rdata);
      @(negedge clk);
      check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vec[i].exp_req});
      check($sformatf("v%0d_addr", i), imem_addr, vec[i].exp_addr);
      check($sformatf("v%0d_inst", i), IF_inst, vec[i].exp_inst);
      check($sformatf("v%0d_pc4", i), IF_pc_4, vec[i].exp_pc4);
      // Scoreboard: every consumed instruction must match the next expected one.
      if (IF_inst !== NOP_V && !stall) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_sb_extra", i), IF_inst, NOP_V);
        end else begin
          check($sformatf("v%0d_sb_order", i), IF_inst, exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
    end
    check("sb_all_delivered", exp_q.size(), 32'd0);

    // Reset while a request is outstanding, then a late response.
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("rst_seq_issue", {31'd0, imem_req}, 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_seq_req_low", {31'd0, imem_req}, 32'd0);
    check("rst_seq_inst", IF_inst, NOP_V);
    check("rst_seq_pc4", IF_pc_4, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rst_seq_first_req", {31'd0, imem_req}, 32'd1);
    check("rst_seq_first_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("rst_seq_late_ignored", IF_inst, NOP_V);
    check("rst_seq_req_held", {31'd0, imem_req}, 32'd1);
    check("rst_seq_addr_held", imem_addr, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 32'h1);
    @(negedge clk);
    check("rst_seq_wait_addr", imem_addr, 32'h4);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_seq_inst_after", IF_inst, 32'h1);
    check("rst_seq_pc4_after", IF_pc_4, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the IF/ID pipeline register. It owns the PC, runs a single-outstanding request/grant/response handshake with instruction memory, and buffers one fetched instruction. It presents `IF_pc_4`/`IF_inst` under the same `stall`/`flush` semantics the IF/ID register uses, and supplies the NOP encoding whenever no valid instruction is ready.

## Interface
- `RESET_PC`, default 32'h0000_0000: address of the first fetch after reset.
- `NOP`, default 32'h0000_0020: bubble encoding presented when the buffer is empty; must match the IF/ID register's NOP.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `stall`  in  1: IF/ID hold; the buffered instruction is not consumed this cycle.
- `flush`  in  1: redirect; the next fetch address is `redirect_pc`.
- `redirect_pc`  in  32: target address, sampled when `flush`=1.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address, word aligned.
- `imem_gnt`  in  1: request accepted this cycle.
- `imem_rvalid`  in  1: response valid, at least one cycle after the grant.
- `imem_rdata`  in  32: instruction word.
- `IF_pc_4`  out  32: buffered PC + 4.
- `IF_inst`  out  32: buffered instruction, or `NOP` when the buffer is empty.

## Operation
- **State:**
  - `fetch_pc` (32): next address to request.
  - FSM {`ISSUE`, `WAIT`}.
  - Buffer {`buf_vld`, `buf_pc`, `buf_inst`}.
  - `kill` (1): discard the outstanding response.
- **Consume:** the buffer is consumed at the edge where `buf_vld` && !`stall`. `flush` also empties the buffer, because IF/ID loads NOP in that case.
- **ISSUE:**
  - `imem_req`=1 when (!`buf_vld` || consume), else 0.
  - On `imem_gnt`: go to `WAIT` and advance `fetch_pc` += 4.
  - `imem_addr`=`fetch_pc`.
  - `imem_req` stays high until granted. Address and request must not change while ungranted, except on `flush`.
- **WAIT:** `imem_req`=0. On `imem_rvalid`:
  - If !`kill`: load `buf_inst`=`imem_rdata`, `buf_pc`=the request address, `buf_vld`=1.
  - Clear `kill` and return to `ISSUE`.
- **Flush (highest priority):**
  - `fetch_pc`←`redirect_pc`.
  - `buf_vld`←0.
  - If in `WAIT` with no `imem_rvalid` in the same cycle, set `kill`. If `imem_rvalid` arrives in the same cycle, drop the data.
  - If in `ISSUE` with `imem_gnt` in the flush cycle, go to `WAIT` with `kill`=1. `fetch_pc` still takes `redirect_pc`, not `redirect_pc`+4.
- **Stall with `buf_vld`=1:** buffer held, no new request issued; an outstanding response cannot arrive into a full buffer by construction.
- **Arithmetic:** PC +4 is a 32-bit wrap; 32'hFFFF_FFFC+4 = 0.
- **Reset:** clears in-flight state. A response arriving after reset release with no request issued since reset is ignored.

## Timing
- **Reset values:**
  - `fetch_pc`=`RESET_PC`, state `ISSUE`, `buf_vld`=0, `kill`=0.
  - `imem_req`=0 during reset.
  - `IF_inst`=`NOP`, `IF_pc_4`=0.
- **Latency:** first `imem_req` in the first cycle after `rst_n` rises. An instruction is visible on `IF_inst` the cycle after its `imem_rvalid`.
- **Throughput:**
  - Zero-wait memory (gnt same cycle, rvalid next cycle) sustains one instruction per 2 cycles.
  - Next issue overlaps consume.
- **Outputs:** `IF_pc_4`/`IF_inst` are registered, with no combinational path from `imem_*`. `imem_req` is combinational from state, `buf_vld` and `stall`.
- **Redirect:** request to `redirect_pc` appears the cycle after `flush`, unless `kill` is pending; in that case it appears after the killed response returns.

## Configuration
- `FETCH_PERF_EN`: when defined, adds outputs `perf_fetch_cnt` (32) and `perf_bubble_cnt` (32).
  - `perf_fetch_cnt` counts non-killed responses.
  - `perf_bubble_cnt` counts cycles with !`buf_vld` && !`stall`.
  - Both reset to 0 and wrap at 2^32.
- Without it: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- **Shared package (`mips_pkg`):**
  - `NOP` constant.
  - Fetch FSM state enum.
  - Word width constant.
- **Sub-module:** `fetch_buf` holds the one-entry buffer (load/consume/clear, `buf_vld`). FSM and PC stay in `fetch_unit`.

## Test plan
- **Reset, zero-wait memory:** `RESET_PC`=0, gnt same cycle, rvalid +1, rdata=addr|1 → `IF_inst` sequence 0x1, 0x5, 0x9 with `IF_pc_4` 4, 8, 12; NOP between.
- **Stall:** assert `stall` 3 cycles while holding inst at PC 8 → `IF_inst`/`IF_pc_4` stable, `imem_req`=0; resumes with PC 12.
- **Flush while WAIT:** flush to 0x100 → stale rdata discarded, `IF_inst`=NOP until the 0x100 fetch returns, then `IF_pc_4`=0x104.
- **Flush same cycle as rvalid/gnt:** data dropped, next `imem_addr`=0x200 exactly once.
- **Delayed gnt (5 cycles):** `imem_req`/`imem_addr` held steady; wrap at 0xFFFF_FFFC → next addr 0.
- **Reset mid-WAIT, then late rvalid:** ignored, `IF_inst`=NOP, first request at `RESET_PC`.
